// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// FSM state encoding, datapath widths and a small op-class helper.
package mdu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned OP_W  = 3;

  typedef enum logic [OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // True for the four ops that occupy the busy window.
  function automatic logic is_arith_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mult_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E/D-stage handshake and HI/LO result bus between the pipeline and mdu_ctrl.
//   start, md_op, rs_val, rt_val : E-stage request
//   md_use_d                     : D-stage instr touches HI/LO
//   busy, md_stall, hi, lo       : unit status, hazard stall, HI/LO registers
interface mdu_ctrl_if;
  import mdu_pkg::*;

  logic                 start;
  logic [OP_W-1:0]      md_op;
  logic [XLEN-1:0]      rs_val;
  logic [XLEN-1:0]      rt_val;
  logic                 md_use_d;
  logic                 busy;
  logic                 md_stall;
  logic [XLEN-1:0]      hi;
  logic [XLEN-1:0]      lo;

  modport master (
    output start, md_op, rs_val, rt_val, md_use_d,
    input  busy, md_stall, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, md_use_d,
    output busy, md_stall, hi, lo
  );
endinterface

// File: rtl/md_arith.sv
// Purely combinational multiply/divide datapath on latched operands.
//   op_i               : latched operation
//   a_i, b_i           : latched operands (rs, rt)
//   res_hi_o, res_lo_o : HI/LO result (product, or remainder/quotient)
//   div_zero_o         : divisor is zero; caller must suppress the commit
module md_arith
  import mdu_pkg::*;
(
  input  md_op_e          op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] res_hi_o,
  output logic [XLEN-1:0] res_lo_o,
  output logic            div_zero_o
);

  logic              sgn;
  logic              neg_a;
  logic              neg_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   mag_q;
  logic [XLEN-1:0]   mag_r;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  always_comb begin
    sgn        = (op_i == MD_MULT) || (op_i == MD_DIV);
    neg_a      = sgn & a_i[XLEN-1];
    neg_b      = sgn & b_i[XLEN-1];
    div_zero_o = (b_i == '0);

    // Low 64 bits of the product of sign/zero-extended operands equal the
    // two's-complement product, so one unsigned multiplier serves both forms.
    prod = {{XLEN{neg_a}}, a_i} * {{XLEN{neg_b}}, b_i};

    // Divide on magnitudes so 0x80000000 / -1 cannot overflow: the
    // magnitude quotient 0x80000000 negates back onto itself.
    mag_a = neg_a ? XLEN'(32'd0 - a_i) : a_i;
    mag_b = neg_b ? XLEN'(32'd0 - b_i) : b_i;
    mag_q = div_zero_o ? '0 : mag_a / mag_b;
    mag_r = div_zero_o ? '0 : mag_a % mag_b;
    quo   = (neg_a ^ neg_b) ? XLEN'(32'd0 - mag_q) : mag_q;
    rem   = neg_a ? XLEN'(32'd0 - mag_r) : mag_r;

    res_hi_o = '0;
    res_lo_o = '0;
    if (is_mult_op(op_i)) begin
      res_hi_o = prod[2*XLEN-1:XLEN];
      res_lo_o = prod[XLEN-1:0];
    end else if ((op_i == MD_DIV) || (op_i == MD_DIVU)) begin
      res_hi_o = rem;
      res_lo_o = quo;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO.
//   clk, reset : clock, synchronous active-high reset
//   bus.slave  : E-stage request, D-stage hazard input, busy/stall/HI/LO out
// md_stall is combinational; all other outputs are registers.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  md_op_e           op_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [XLEN-1:0]  hi_q;
  logic [XLEN-1:0]  lo_q;
  logic             busy_q;

  md_op_e           op_in;
  logic [XLEN-1:0]  res_hi;
  logic [XLEN-1:0]  res_lo;
  logic             div_zero;

  assign op_in = md_op_e'(bus.md_op);

  md_arith u_arith (
    .op_i       (op_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .res_hi_o   (res_hi),
    .res_lo_o   (res_lo),
    .div_zero_o (div_zero)
  );

  // FSM, latency counter, operand latches and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && is_arith_op(op_in)) begin
            op_q    <= op_in;
            a_q     <= bus.rs_val;
            b_q     <= bus.rt_val;
            cnt_q   <= is_mult_op(op_in) ? MULT_CNT : DIV_CNT;
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end else if (op_in == MD_MTHI) begin
            hi_q <= bus.rs_val;
          end else if (op_in == MD_MTLO) begin
            lo_q <= bus.rs_val;
          end
        end
        S_RUN: begin
          // Last busy cycle: commit and free the unit for a zero-bubble restart.
          if (cnt_q == CNT_W'(1)) begin
            if (!div_zero || is_mult_op(op_q)) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
            cnt_q   <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.md_stall = bus.md_use_d & (busy_q | bus.start);

endmodule
